// File: rtl/poly_horner_seq.sv
// poly_horner_seq: sequential Horner-rule polynomial evaluator with stream handshakes
module poly_horner_seq #(
  parameter int DATA_W = 16,
  parameter int DEGREE = 3,
  parameter int COEF_W = 8,
  parameter logic [(DEGREE+1)*COEF_W-1:0] COEFS = {8'd1, 8'd2, 8'd1, 8'd1},
  parameter int OUT_W = 48
) (
  input  logic              in_clock,
  input  logic              in_reset,
  input  logic              axis_s_tvalid,
  output logic              axis_s_tready,
  input  logic [DATA_W-1:0] axis_s_tdata,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic [OUT_W-1:0]  axis_m_tdata,
  output logic              axis_m_tuser,
  output logic              busy
);
  localparam int SW = OUT_W + DATA_W + 1;
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  state_t state;
  logic [OUT_W-1:0] acc;
  logic [DATA_W-1:0] x;
  logic [3:0] cnt;
  logic [3:0] idx;
  logic ovf;
  logic [COEF_W-1:0] coef;
  logic [SW-1:0] step;
  logic step_ovf;
  assign axis_s_tready = state == IDLE;
  assign axis_m_tvalid = state == OUT;
  assign busy = state != IDLE;
  // one Horner multiply-add, wide enough that the carry-out above OUT_W is never lost
  always_comb begin
    idx = cnt - 4'd1;
    coef = COEF_W'(COEFS >> (int'(idx) * COEF_W));
    step = SW'(acc) * SW'(x) + SW'(coef);
    step_ovf = |step[SW-1:OUT_W];
  end
  // control FSM; result registers only change when a new result completes
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state <= IDLE;
      acc <= '0;
      x <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      axis_m_tdata <= '0;
      axis_m_tuser <= 1'b0;
    end else begin
      case (state)
        IDLE: if (axis_s_tvalid) begin
          x <= axis_s_tdata;
          acc <= OUT_W'(COEFS[DEGREE*COEF_W +: COEF_W]);
          ovf <= 1'b0;
          cnt <= 4'(DEGREE);
          state <= CALC;
        end
        CALC: begin
          acc <= step[OUT_W-1:0];
          ovf <= ovf | step_ovf;
          cnt <= idx;
          if (cnt == 4'd1) begin
            state <= OUT;
            axis_m_tdata <= step[OUT_W-1:0];
            axis_m_tuser <= ovf | step_ovf;
          end
        end
        OUT: if (axis_m_tready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_horner_seq.sv
// tb_poly_horner_seq: scoreboard bench over three parameterisations of poly_horner_seq
module tb_poly_horner_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid[3], s_ready[3], m_valid[3], m_ready[3], m_user[3], busy[3];
  logic [15:0] s_data[3];
  logic [47:0] m_data[3];
  logic [47:0] m_data0, m_data2;
  logic [31:0] m_data1;
  logic [48:0] q[3][$];
  logic [48:0] exp_e;
  int deg[3] = '{3, 3, 1};
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    m_data[0] = m_data0;
    m_data[1] = {16'b0, m_data1};
    m_data[2] = m_data2;
  end

  poly_horner_seq dut0 (
    .in_clock(clk), .in_reset(rst),
    .axis_s_tvalid(s_valid[0]), .axis_s_tready(s_ready[0]), .axis_s_tdata(s_data[0]),
    .axis_m_tvalid(m_valid[0]), .axis_m_tready(m_ready[0]), .axis_m_tdata(m_data0),
    .axis_m_tuser(m_user[0]), .busy(busy[0])
  );

  poly_horner_seq #(.OUT_W(32)) dut1 (
    .in_clock(clk), .in_reset(rst),
    .axis_s_tvalid(s_valid[1]), .axis_s_tready(s_ready[1]), .axis_s_tdata(s_data[1]),
    .axis_m_tvalid(m_valid[1]), .axis_m_tready(m_ready[1]), .axis_m_tdata(m_data1),
    .axis_m_tuser(m_user[1]), .busy(busy[1])
  );

  poly_horner_seq #(.DEGREE(1), .COEFS({8'd3, 8'd7})) dut2 (
    .in_clock(clk), .in_reset(rst),
    .axis_s_tvalid(s_valid[2]), .axis_s_tready(s_ready[2]), .axis_s_tdata(s_data[2]),
    .axis_m_tvalid(m_valid[2]), .axis_m_tready(m_ready[2]), .axis_m_tdata(m_data2),
    .axis_m_tuser(m_user[2]), .busy(busy[2])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // monitor: every completed output handshake is matched against the scoreboard
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && m_valid[k] && m_ready[k]) begin
        if (q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out%0d: got data %0h with no expected result", k, m_data[k]);
        end else begin
          exp_e = q[k].pop_front();
          chk($sformatf("out%0d_data", k), m_data[k], exp_e[47:0]);
          chk($sformatf("out%0d_user", k), m_user[k], exp_e[48]);
        end
      end
    end
  end

  task automatic send(input int k, input logic [15:0] x, input logic [47:0] d, input logic u);
    int n = 0;
    q[k].push_back({u, d});
    s_data[k] = x;
    s_valid[k] = 1'b1;
    while (!s_ready[k] && n < 50) begin
      tick;
      n++;
    end
    chk("accept_in_time", n < 50, 1);
    tick;
    s_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!m_valid[k] && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic run(input int k, input logic [15:0] x, input logic [47:0] d, input logic u);
    int n;
    send(k, x, d, u);
    chk($sformatf("busy_calc%0d", k), busy[k], 1);
    chk($sformatf("s_ready_calc%0d", k), s_ready[k], 0);
    wait_valid(k, n);
    chk($sformatf("latency%0d_x%0h", k, x), n, deg[k]);
    tick;
    chk($sformatf("valid_one_cycle%0d", k), m_valid[k], 0);
    chk($sformatf("s_ready_after%0d", k), s_ready[k], 1);
    chk($sformatf("data_retained%0d", k), m_data[k], d);
    chk($sformatf("busy_idle%0d", k), busy[k], 0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      s_valid[k] = 1'b0;
      s_data[k] = '0;
      m_ready[k] = 1'b1;
    end
    tick;
    tick;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_s_ready%0d", k), s_ready[k], 1);
      chk($sformatf("rst_m_valid%0d", k), m_valid[k], 0);
      chk($sformatf("rst_m_data%0d", k), m_data[k], 0);
      chk($sformatf("rst_m_user%0d", k), m_user[k], 0);
      chk($sformatf("rst_busy%0d", k), busy[k], 0);
    end
    rst = 1'b0;
    tick;
    run(0, 16'd0, 48'd1, 1'b0);
    run(0, 16'd1, 48'd5, 1'b0);
    run(0, 16'd2, 48'd19, 1'b0);
    run(0, 16'hFFFF, 48'hFFFF00000001, 1'b0);
    run(1, 16'hFFFF, 48'd1, 1'b1);
    run(1, 16'd2, 48'd19, 1'b0);
    run(2, 16'd10, 48'd37, 1'b0);
    // DEGREE=1 with s_valid held high through CALC: only one sample taken
    q[2].push_back({1'b0, 48'd37});
    s_data[2] = 16'd10;
    s_valid[2] = 1'b1;
    tick;
    s_data[2] = 16'd5;
    chk("held_valid_calc_busy", busy[2], 1);
    tick;
    chk("held_valid_out", m_valid[2], 1);
    s_valid[2] = 1'b0;
    tick;
    tick;
    tick;
    chk("held_valid_idle_after", busy[2], 0);
    chk("held_valid_data", m_data[2], 37);
    // backpressure on dut0
    m_ready[0] = 1'b0;
    send(0, 16'd2, 48'd19, 1'b0);
    wait_valid(0, n);
    chk("bp_latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", m_valid[0], 1);
      chk("bp_data", m_data[0], 19);
      chk("bp_s_ready", s_ready[0], 0);
      tick;
    end
    m_ready[0] = 1'b1;
    tick;
    chk("bp_s_ready_after", s_ready[0], 1);
    chk("bp_valid_after", m_valid[0], 0);
    // reset during the second CALC cycle discards the sample
    s_data[0] = 16'd3;
    s_valid[0] = 1'b1;
    tick;
    s_valid[0] = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_calc_s_ready", s_ready[0], 1);
    chk("rst_calc_busy", busy[0], 0);
    chk("rst_calc_m_data", m_data[0], 0);
    for (int i = 0; i < 6; i++) tick;
    chk("rst_calc_no_valid", m_valid[0], 0);
    run(0, 16'd1, 48'd5, 1'b0);
    // reset while holding a result in OUT discards it
    m_ready[0] = 1'b0;
    s_data[0] = 16'd2;
    s_valid[0] = 1'b1;
    tick;
    s_valid[0] = 1'b0;
    wait_valid(0, n);
    chk("rst_out_reached", m_valid[0], 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_out_valid", m_valid[0], 0);
    chk("rst_out_s_ready", s_ready[0], 1);
    m_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    run(0, 16'd2, 48'd19, 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("queue_empty%0d", k), q[k].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/poly_horner_seq.md
POLY_HORNER_SEQ -- requirements
Module: poly_horner_seq

Interface
REQ-001 Parameter DATA_W, default 16: width of input sample x, unsigned.
REQ-002 Parameter DEGREE, default 3: polynomial degree N; legal range 1..8.
REQ-003 Parameter COEF_W, default 8: width of each unsigned coefficient.
REQ-004 Parameter COEFS, width (DEGREE+1)*COEF_W, default {8'd1,8'd2,8'd1,8'd1}: coefficient a_i in bits [i*COEF_W +: COEF_W], giving x^3+2x^2+x+1 by default.
REQ-005 Parameter OUT_W, default 48: result width; results are reduced mod 2^OUT_W.
REQ-006 in_clock  input  1  sole clock; all state updates on rising edge.
REQ-007 in_reset  input  1  synchronous, active-high reset.
REQ-008 axis_s_tvalid  input  1  input sample valid.
REQ-009 axis_s_tready  output  1  block can accept a sample.
REQ-010 axis_s_tdata  input  DATA_W  sample x.
REQ-011 axis_m_tvalid  output  1  result valid.
REQ-012 axis_m_tready  input  1  downstream accepts result.
REQ-013 axis_m_tdata  output  OUT_W  W(x) mod 2^OUT_W.
REQ-014 axis_m_tuser  output  1  overflow flag: true result >= 2^OUT_W.
REQ-015 busy  output  1  high in states CALC and OUT.

Function
REQ-016 The block SHALL evaluate W(x) = sum a_i*x^i by Horner's rule using one multiplier, one multiply-add step per cycle.
REQ-017 States SHALL be IDLE, CALC, OUT; axis_s_tready = 1 only in IDLE; axis_m_tvalid = 1 only in OUT; both are registered-state decodes.
REQ-018 IDLE: on edge with axis_s_tvalid=1, capture x, load acc <= a_N, clear ovf, load step counter <= DEGREE, go to CALC; else stay.
REQ-019 CALC: each edge, acc <= (acc*x + a_(cnt-1)) mod 2^OUT_W, cnt <= cnt-1; on the edge where cnt=1, go to OUT.
REQ-020 Latency: accept edge plus exactly DEGREE CALC edges; axis_m_tvalid is high in the cycle after the DEGREE-th CALC edge (default: 4th cycle after accept edge).
REQ-021 Step arithmetic SHALL be evaluated at OUT_W+DATA_W+1 bits; ovf SHALL be set (sticky for this sample) if any step result's bits above OUT_W-1 are nonzero.
REQ-022 OUT: axis_m_tdata = acc, axis_m_tuser = ovf, held stable while axis_m_tready=0; on edge with axis_m_tready=1 go to IDLE.
REQ-023 axis_m_tvalid SHALL NOT depend combinationally on axis_m_tready.
REQ-024 Input samples presented outside IDLE SHALL be ignored (not captured, no state change).
REQ-025 Throughput: at most one sample per DEGREE+2 cycles with axis_m_tready held high.
REQ-026 axis_m_tdata and axis_m_tuser SHALL retain last values after leaving OUT until the next result overwrites them.

Reset
REQ-027 in_reset=1 at an edge SHALL force state IDLE, acc=0, x=0, cnt=0, ovf=0, taking priority over all other events.
REQ-028 After reset: axis_s_tready=1, axis_m_tvalid=0, axis_m_tdata=0, axis_m_tuser=0, busy=0.
REQ-029 Reset asserted mid-CALC or in OUT SHALL discard the in-flight sample with no result emitted.

Verification
REQ-030 Defaults, m_tready=1: x=0 -> tdata=1; x=1 -> 5; x=2 -> 19; tuser=0 each; tvalid one cycle each.
REQ-031 Defaults, x=65535 -> tdata=0xFFFF00000001, tuser=0, tvalid in 4th cycle after accept.
REQ-032 OUT_W=32, x=65535 -> tdata=0x00000001, tuser=1.
REQ-033 Backpressure: x=2, m_tready low 10 cycles -> tdata=19 stable, tvalid high, s_tready low throughout; accepted on first m_tready=1 edge, s_tready=1 next cycle.
REQ-034 Reset pulse during 2nd CALC cycle -> no tvalid, s_tready=1 next cycle; following x=1 -> 5.
REQ-035 DEGREE=1, COEFS={8'd3,8'd7}: x=10 -> tdata=37, tvalid 2nd cycle after accept; s_tvalid held high during CALC captures no extra samples.
